// File: rtl/mp_ram_pkg.sv
// Shared types and constants for the multi-port arbitrated RAM.
// prio_rank maps a port index to its rank; rank 0 is the highest priority.
package mp_ram_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  localparam int LAT_1           = 1;
  localparam int LAT_2           = 2;
  localparam int COLLISION_CNT_W = 16;

  function automatic int prio_rank(
    input int idx,
    input int ptr,
    input int n
  );
    return (idx - ptr + n) % n;
  endfunction

endpackage

// File: rtl/mp_ram_arb_if.sv
// Per-port request/response bundle for mp_ram_arb.
// Every field is packed by port index, lowest port in the LSBs.
interface mp_ram_arb_if #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 6,
  parameter int WIDTH     = 32,
  parameter int WE_W      = 4
);

  logic [NUM_PORTS-1:0]        REQ_VALID;
  logic [NUM_PORTS-1:0]        REQ_READY;
  logic [NUM_PORTS*ADDR_W-1:0] REQ_ADDR;
  logic [NUM_PORTS*WIDTH-1:0]  REQ_WDATA;
  logic [NUM_PORTS*WE_W-1:0]   REQ_WSTRB;
  logic [NUM_PORTS-1:0]        RSP_VALID;
  logic [NUM_PORTS*WIDTH-1:0]  RSP_RDATA;
  logic [NUM_PORTS-1:0]        RSP_ERR;

  modport master (
    output REQ_VALID, REQ_ADDR, REQ_WDATA, REQ_WSTRB,
    input  REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR
  );

  modport slave (
    input  REQ_VALID, REQ_ADDR, REQ_WDATA, REQ_WSTRB,
    output REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR
  );

endinterface

// File: rtl/mp_ram_conflict_arb.sv
// Same-address conflict arbiter: grants ready per port, flags stalls and
// computes the next round-robin pointer from the lowest-ranked winner.
module mp_ram_conflict_arb
  import mp_ram_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 6,
  parameter int PTR_W     = 1
) (
  input  logic [NUM_PORTS-1:0]             valid,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0] addr,
  input  logic [NUM_PORTS-1:0]             is_write,
  input  logic [NUM_PORTS-1:0]             in_range,
  input  logic [PTR_W-1:0]                 ptr,
  output logic [NUM_PORTS-1:0]             ready,
  output logic                             stall_any,
  output logic [PTR_W-1:0]                 ptr_nxt
);

  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] conf;
  int rank [NUM_PORTS];
  int win;
  int win_rank;

  always_comb begin
    conf = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      rank[p] = prio_rank(p, int'(ptr), NUM_PORTS);
      for (int q = 0; q < NUM_PORTS; q++) begin
        if (p != q) begin
          conf[p][q] = valid[p] & valid[q]
                     & in_range[p] & in_range[q]
                     & (addr[p] == addr[q])
                     & (is_write[p] | is_write[q]);
        end
      end
    end
  end

  always_comb begin
    ready = valid;
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int q = 0; q < NUM_PORTS; q++) begin
        if (conf[p][q] && rank[q] < rank[p]) begin
          ready[p] = 1'b0;
        end
      end
    end
  end

  assign stall_any = |(valid & ~ready);

  // Pointer lands just past the lowest-priority port that won a conflict.
  always_comb begin
    win      = 0;
    win_rank = -1;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (ready[p] && (|conf[p]) && rank[p] > win_rank) begin
        win      = p;
        win_rank = rank[p];
      end
    end
    ptr_nxt = PTR_W'((win + 1) % NUM_PORTS);
  end

endmodule

// File: rtl/mp_ram_arb.sv
// N-port byte-strobed RAM with same-address write arbitration,
// fixed-latency responses, range errors and a stall counter.
module mp_ram_arb
  import mp_ram_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 64,
  parameter int STRB_WIDTH   = 8,
  parameter int NUM_PORTS    = 2,
  parameter int READ_LATENCY = 1,
  parameter int WRITE_FIRST  = 0,
  parameter int ARB_MODE     = 0
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  mp_ram_arb_if.slave                bus,
  output logic [COLLISION_CNT_W-1:0] COLLISION_CNT
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int WE_W   = WIDTH / STRB_WIDTH;
  localparam int PTR_W  = $clog2(NUM_PORTS);
  localparam arb_mode_e MODE = (ARB_MODE == 1) ? ARB_RR : ARB_FIXED;

  logic [NUM_PORTS-1:0][ADDR_W-1:0] addr;
  logic [NUM_PORTS-1:0][WIDTH-1:0]  wdata;
  logic [NUM_PORTS-1:0][WE_W-1:0]   wstrb;
  logic [NUM_PORTS-1:0]             valid;
  logic [NUM_PORTS-1:0]             ready;
  logic [NUM_PORTS-1:0]             is_wr;
  logic [NUM_PORTS-1:0]             in_rng;
  logic [NUM_PORTS-1:0]             acc;
  logic                             stall_any;
  logic [PTR_W-1:0]                 ptr;
  logic [PTR_W-1:0]                 ptr_nxt;

  logic [NUM_PORTS-1:0][WIDTH-1:0]  old_w;
  logic [NUM_PORTS-1:0][WIDTH-1:0]  mrg_w;
  logic [NUM_PORTS-1:0][WIDTH-1:0]  rsp_d;

  logic [NUM_PORTS-1:0]             s1_vld;
  logic [NUM_PORTS-1:0]             s1_err;
  logic [NUM_PORTS-1:0][WIDTH-1:0]  s1_data;

  logic [WIDTH-1:0] mem [DEPTH];

  assign addr  = bus.REQ_ADDR;
  assign wdata = bus.REQ_WDATA;
  assign wstrb = bus.REQ_WSTRB;
  assign valid = bus.REQ_VALID;
  assign acc   = valid & ready;

  assign bus.REQ_READY = ready;

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      is_wr[p]  = |wstrb[p];
      in_rng[p] = int'(addr[p]) < DEPTH;
    end
  end

  mp_ram_conflict_arb #(
    .NUM_PORTS (NUM_PORTS),
    .ADDR_W    (ADDR_W),
    .PTR_W     (PTR_W)
  ) u_arb (
    .valid     (valid),
    .addr      (addr),
    .is_write  (is_wr),
    .in_range  (in_rng),
    .ptr       (ptr),
    .ready     (ready),
    .stall_any (stall_any),
    .ptr_nxt   (ptr_nxt)
  );

  // Out-of-range lanes read as zero so their responses carry no data.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      old_w[p] = in_rng[p] ? mem[addr[p]] : '0;
      mrg_w[p] = old_w[p];
      for (int b = 0; b < WE_W; b++) begin
        if (wstrb[p][b]) begin
          mrg_w[p][b*STRB_WIDTH +: STRB_WIDTH] =
            wdata[p][b*STRB_WIDTH +: STRB_WIDTH];
        end
      end
      if (!in_rng[p]) begin
        rsp_d[p] = '0;
      end else if (is_wr[p] && WRITE_FIRST != 0) begin
        rsp_d[p] = mrg_w[p];
      end else begin
        rsp_d[p] = old_w[p];
      end
    end
  end

  always_ff @(posedge CLK) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (acc[p] && is_wr[p] && in_rng[p]) begin
        mem[addr[p]] <= mrg_w[p];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_vld  <= '0;
      s1_err  <= '0;
      s1_data <= '0;
    end else begin
      s1_vld <= acc;
      s1_err <= acc & ~in_rng;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (acc[p]) begin
          s1_data[p] <= rsp_d[p];
        end
      end
    end
  end

  if (READ_LATENCY == LAT_2) begin : g_lat2
    logic [NUM_PORTS-1:0]            s2_vld;
    logic [NUM_PORTS-1:0]            s2_err;
    logic [NUM_PORTS-1:0][WIDTH-1:0] s2_data;

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        s2_vld  <= '0;
        s2_err  <= '0;
        s2_data <= '0;
      end else begin
        s2_vld  <= s1_vld;
        s2_err  <= s1_err;
        s2_data <= s1_data;
      end
    end

    assign bus.RSP_VALID = s2_vld;
    assign bus.RSP_ERR   = s2_err;
    assign bus.RSP_RDATA = s2_data;
  end else begin : g_lat1
    assign bus.RSP_VALID = s1_vld;
    assign bus.RSP_ERR   = s1_err;
    assign bus.RSP_RDATA = s1_data;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ptr           <= '0;
      COLLISION_CNT <= '0;
    end else begin
      if (MODE == ARB_RR && stall_any) begin
        ptr <= ptr_nxt;
      end
      if (stall_any && COLLISION_CNT != '1) begin
        COLLISION_CNT <= COLLISION_CNT + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mp_ram_arb.sv
// Directed bench for mp_ram_arb: three configurations share one clock
// (2-port fixed DEPTH=48, 3-port round-robin, 2-port latency-2 write-first).
module tb_mp_ram_arb;

  logic CLK = 1'b0;
  logic RST_N;
  logic [15:0] cnt0, cnt1, cnt2;
  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  mp_ram_arb_if #(.NUM_PORTS(2), .ADDR_W(6), .WIDTH(32), .WE_W(4)) a0 ();
  mp_ram_arb_if #(.NUM_PORTS(3), .ADDR_W(6), .WIDTH(32), .WE_W(4)) a1 ();
  mp_ram_arb_if #(.NUM_PORTS(2), .ADDR_W(6), .WIDTH(32), .WE_W(4)) a2 ();

  mp_ram_arb #(
    .WIDTH(32), .DEPTH(48), .STRB_WIDTH(8), .NUM_PORTS(2),
    .READ_LATENCY(1), .WRITE_FIRST(0), .ARB_MODE(0)
  ) u0 (.CLK(CLK), .RST_N(RST_N), .bus(a0.slave), .COLLISION_CNT(cnt0));

  mp_ram_arb #(
    .WIDTH(32), .DEPTH(64), .STRB_WIDTH(8), .NUM_PORTS(3),
    .READ_LATENCY(1), .WRITE_FIRST(0), .ARB_MODE(1)
  ) u1 (.CLK(CLK), .RST_N(RST_N), .bus(a1.slave), .COLLISION_CNT(cnt1));

  mp_ram_arb #(
    .WIDTH(32), .DEPTH(64), .STRB_WIDTH(8), .NUM_PORTS(2),
    .READ_LATENCY(2), .WRITE_FIRST(1), .ARB_MODE(0)
  ) u2 (.CLK(CLK), .RST_N(RST_N), .bus(a2.slave), .COLLISION_CNT(cnt2));

  task automatic drv0(input int p, input logic v, input logic [5:0] a,
                      input logic [31:0] d, input logic [3:0] s);
    a0.REQ_VALID[p]        = v;
    a0.REQ_ADDR[p*6 +: 6]  = a;
    a0.REQ_WDATA[p*32 +: 32] = d;
    a0.REQ_WSTRB[p*4 +: 4] = s;
  endtask

  task automatic drv2(input int p, input logic v, input logic [5:0] a,
                      input logic [31:0] d, input logic [3:0] s);
    a2.REQ_VALID[p]        = v;
    a2.REQ_ADDR[p*6 +: 6]  = a;
    a2.REQ_WDATA[p*32 +: 32] = d;
    a2.REQ_WSTRB[p*4 +: 4] = s;
  endtask

  task automatic test_reset();
    checks++;
    if (a0.RSP_VALID !== 2'b00) begin
      failures++;
      $display("FAIL reset_rsp_valid got=%b exp=00", a0.RSP_VALID);
    end
    checks++;
    if (a0.RSP_RDATA !== 64'h0 || a0.RSP_ERR !== 2'b00) begin
      failures++;
      $display("FAIL reset_rsp_data got=%h/%b exp=0/00", a0.RSP_RDATA, a0.RSP_ERR);
    end
    checks++;
    if (cnt0 !== 16'd0 || cnt1 !== 16'd0 || a2.RSP_VALID !== 2'b00) begin
      failures++;
      $display("FAIL reset_cnt got=%0d/%0d/%b exp=0/0/00", cnt0, cnt1, a2.RSP_VALID);
    end
  endtask

  task automatic test_single_read();
    @(negedge CLK);
    drv0(0, 1'b1, 6'd5, 32'hDEADBEEF, 4'hF);
    #1;
    checks++;
    if (a0.REQ_READY !== 2'b01) begin
      failures++;
      $display("FAIL single_ready got=%b exp=01", a0.REQ_READY);
    end
    @(negedge CLK);
    checks++;
    if (a0.RSP_VALID !== 2'b01 || a0.RSP_ERR !== 2'b00) begin
      failures++;
      $display("FAIL single_wr_rsp got=%b/%b exp=01/00", a0.RSP_VALID, a0.RSP_ERR);
    end
    drv0(0, 1'b1, 6'd5, 32'h0, 4'h0);
    @(negedge CLK);
    checks++;
    if (a0.RSP_VALID !== 2'b01 || a0.RSP_RDATA[31:0] !== 32'hDEADBEEF ||
        a0.RSP_ERR !== 2'b00) begin
      failures++;
      $display("FAIL single_rd got=%b/%h/%b exp=01/deadbeef/00",
               a0.RSP_VALID, a0.RSP_RDATA[31:0], a0.RSP_ERR);
    end
    drv0(0, 1'b0, 6'd0, 32'h0, 4'h0);
    @(negedge CLK);
    checks++;
    if (a0.RSP_VALID !== 2'b00) begin
      failures++;
      $display("FAIL single_pulse got=%b exp=00", a0.RSP_VALID);
    end
  endtask

  task automatic test_strobe();
    @(negedge CLK);
    drv0(1, 1'b1, 6'd3, 32'h11223344, 4'hF);
    @(negedge CLK);
    drv0(1, 1'b1, 6'd3, 32'hAABBCCDD, 4'b0101);
    @(negedge CLK);
    checks++;
    if (a0.RSP_VALID !== 2'b10 || a0.RSP_RDATA[63:32] !== 32'h11223344) begin
      failures++;
      $display("FAIL strobe_old_word got=%b/%h exp=10/11223344",
               a0.RSP_VALID, a0.RSP_RDATA[63:32]);
    end
    drv0(1, 1'b1, 6'd3, 32'h0, 4'h0);
    @(negedge CLK);
    checks++;
    if (a0.RSP_RDATA[63:32] !== 32'h11BB33DD) begin
      failures++;
      $display("FAIL strobe_merge got=%h exp=11bb33dd", a0.RSP_RDATA[63:32]);
    end
    drv0(1, 1'b0, 6'd0, 32'h0, 4'h0);
  endtask

  task automatic test_fixed_collision();
    @(negedge CLK);
    drv0(0, 1'b1, 6'd7, 32'h1, 4'hF);
    drv0(1, 1'b1, 6'd7, 32'h2, 4'hF);
    #1;
    checks++;
    if (a0.REQ_READY !== 2'b01) begin
      failures++;
      $display("FAIL fix_coll_ready got=%b exp=01", a0.REQ_READY);
    end
    @(negedge CLK);
    drv0(0, 1'b0, 6'd0, 32'h0, 4'h0);
    #1;
    checks++;
    if (a0.REQ_READY !== 2'b10 || cnt0 !== 16'd1) begin
      failures++;
      $display("FAIL fix_coll_retry got=%b/%0d exp=10/1", a0.REQ_READY, cnt0);
    end
    @(negedge CLK);
    checks++;
    if (a0.RSP_VALID !== 2'b10) begin
      failures++;
      $display("FAIL fix_coll_rsp got=%b exp=10", a0.RSP_VALID);
    end
    drv0(1, 1'b0, 6'd0, 32'h0, 4'h0);
    drv0(0, 1'b1, 6'd7, 32'h0, 4'h0);
    @(negedge CLK);
    checks++;
    if (a0.RSP_RDATA[31:0] !== 32'h2 || cnt0 !== 16'd1) begin
      failures++;
      $display("FAIL fix_coll_final got=%h/%0d exp=2/1", a0.RSP_RDATA[31:0], cnt0);
    end
    drv0(0, 1'b0, 6'd0, 32'h0, 4'h0);
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_rdy [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    @(negedge CLK);
    a1.REQ_VALID = 3'b111;
    a1.REQ_ADDR  = '0;
    a1.REQ_WDATA = {32'h12, 32'h11, 32'h10};
    a1.REQ_WSTRB = 12'hFFF;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (a1.REQ_READY !== exp_rdy[i]) begin
        failures++;
        $display("FAIL rr_grant_%0d got=%b exp=%b", i, a1.REQ_READY, exp_rdy[i]);
      end
      @(negedge CLK);
    end
    a1.REQ_VALID = 3'b011;
    a1.REQ_WSTRB = '0;
    #1;
    checks++;
    if (cnt1 !== 16'd6 || a1.REQ_READY !== 3'b011) begin
      failures++;
      $display("FAIL rr_cnt_rdrd got=%0d/%b exp=6/011", cnt1, a1.REQ_READY);
    end
    @(negedge CLK);
    a1.REQ_VALID = 3'b000;
    checks++;
    if (cnt1 !== 16'd6 || a1.RSP_VALID !== 3'b011 ||
        a1.RSP_RDATA[31:0] !== 32'h12) begin
      failures++;
      $display("FAIL rr_rdrd_rsp got=%0d/%b/%h exp=6/011/12",
               cnt1, a1.RSP_VALID, a1.RSP_RDATA[31:0]);
    end
  endtask

  task automatic test_read_during_write();
    @(negedge CLK);
    drv0(0, 1'b1, 6'd9, 32'h0, 4'hF);
    drv2(0, 1'b1, 6'd9, 32'h0, 4'hF);
    @(negedge CLK);
    drv0(0, 1'b1, 6'd9, 32'h55, 4'h1);
    drv2(0, 1'b1, 6'd9, 32'h55, 4'h1);
    #1;
    checks++;
    if (a2.RSP_VALID !== 2'b00) begin
      failures++;
      $display("FAIL rdw_lat2_early got=%b exp=00", a2.RSP_VALID);
    end
    @(negedge CLK);
    drv0(0, 1'b0, 6'd0, 32'h0, 4'h0);
    drv2(0, 1'b0, 6'd0, 32'h0, 4'h0);
    checks++;
    if (a0.RSP_VALID !== 2'b01 || a0.RSP_RDATA[31:0] !== 32'h0) begin
      failures++;
      $display("FAIL rdw_old got=%b/%h exp=01/0", a0.RSP_VALID, a0.RSP_RDATA[31:0]);
    end
    checks++;
    if (a2.RSP_VALID !== 2'b01 || a2.RSP_RDATA[31:0] !== 32'h0) begin
      failures++;
      $display("FAIL rdw_lat2_first got=%b/%h exp=01/0", a2.RSP_VALID, a2.RSP_RDATA[31:0]);
    end
    @(negedge CLK);
    checks++;
    if (a2.RSP_VALID !== 2'b01 || a2.RSP_RDATA[31:0] !== 32'h55) begin
      failures++;
      $display("FAIL rdw_new got=%b/%h exp=01/55", a2.RSP_VALID, a2.RSP_RDATA[31:0]);
    end
    @(negedge CLK);
    checks++;
    if (a2.RSP_VALID !== 2'b00) begin
      failures++;
      $display("FAIL rdw_lat2_end got=%b exp=00", a2.RSP_VALID);
    end
  endtask

  task automatic test_out_of_range();
    @(negedge CLK);
    drv0(0, 1'b1, 6'd2, 32'hCAFEF00D, 4'hF);
    @(negedge CLK);
    drv0(0, 1'b1, 6'd50, 32'hFFFFFFFF, 4'hF);
    drv0(1, 1'b1, 6'd50, 32'hFFFFFFFF, 4'hF);
    #1;
    checks++;
    if (a0.REQ_READY !== 2'b11) begin
      failures++;
      $display("FAIL oor_ready got=%b exp=11", a0.REQ_READY);
    end
    @(negedge CLK);
    checks++;
    if (a0.RSP_VALID !== 2'b11 || a0.RSP_ERR !== 2'b11 || a0.RSP_RDATA !== 64'h0) begin
      failures++;
      $display("FAIL oor_wr_rsp got=%b/%b/%h exp=11/11/0",
               a0.RSP_VALID, a0.RSP_ERR, a0.RSP_RDATA);
    end
    drv0(1, 1'b0, 6'd0, 32'h0, 4'h0);
    drv0(0, 1'b1, 6'd50, 32'h0, 4'h0);
    @(negedge CLK);
    checks++;
    if (a0.RSP_ERR !== 2'b01 || a0.RSP_RDATA[31:0] !== 32'h0) begin
      failures++;
      $display("FAIL oor_rd got=%b/%h exp=01/0", a0.RSP_ERR, a0.RSP_RDATA[31:0]);
    end
    drv0(0, 1'b1, 6'd2, 32'h0, 4'h0);
    @(negedge CLK);
    checks++;
    if (a0.RSP_RDATA[31:0] !== 32'hCAFEF00D || a0.RSP_ERR !== 2'b00 || cnt0 !== 16'd1) begin
      failures++;
      $display("FAIL oor_no_write got=%h/%b/%0d exp=cafef00d/00/1",
               a0.RSP_RDATA[31:0], a0.RSP_ERR, cnt0);
    end
    drv0(0, 1'b0, 6'd0, 32'h0, 4'h0);
  endtask

  task automatic test_reset_mid();
    @(negedge CLK);
    drv0(0, 1'b1, 6'd5, 32'h0, 4'h0);
    @(posedge CLK);
    #2;
    checks++;
    if (a0.RSP_VALID !== 2'b01 || cnt0 !== 16'd1) begin
      failures++;
      $display("FAIL rstmid_before got=%b/%0d exp=01/1", a0.RSP_VALID, cnt0);
    end
    RST_N = 1'b0;
    #1;
    checks++;
    if (a0.RSP_VALID !== 2'b00 || cnt0 !== 16'd0 || cnt1 !== 16'd0) begin
      failures++;
      $display("FAIL rstmid_drop got=%b/%0d/%0d exp=00/0/0", a0.RSP_VALID, cnt0, cnt1);
    end
    @(negedge CLK);
    drv0(0, 1'b0, 6'd0, 32'h0, 4'h0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    drv0(0, 1'b1, 6'd5, 32'h0, 4'h0);
    @(negedge CLK);
    checks++;
    if (a0.RSP_VALID !== 2'b01 || a0.RSP_RDATA[31:0] !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL rstmid_mem got=%b/%h exp=01/deadbeef",
               a0.RSP_VALID, a0.RSP_RDATA[31:0]);
    end
    drv0(0, 1'b0, 6'd0, 32'h0, 4'h0);
  endtask

  initial begin
    RST_N = 1'b0;
    a0.REQ_VALID = '0; a0.REQ_ADDR = '0; a0.REQ_WDATA = '0; a0.REQ_WSTRB = '0;
    a1.REQ_VALID = '0; a1.REQ_ADDR = '0; a1.REQ_WDATA = '0; a1.REQ_WSTRB = '0;
    a2.REQ_VALID = '0; a2.REQ_ADDR = '0; a2.REQ_WDATA = '0; a2.REQ_WSTRB = '0;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    test_reset();
    test_single_read();
    test_strobe();
    test_fixed_collision();
    test_round_robin();
    test_read_during_write();
    test_out_of_range();
    test_reset_mid();
    @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
